// File: rtl/axby_pkg.sv
// axby_pkg: shared state encoding, CMD bit positions and STATUS bit positions for the AXBY sequencer.
package axby_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_MX   = 3'd2,
        ST_MY   = 3'd3,
        ST_DONE = 3'd4,
        ST_HOLD = 3'd5
    } state_t;

    localparam int CMD_RESI = 7;
    localparam int CMD_PLX  = 6;
    localparam int CMD_SHX  = 5;
    localparam int CMD_PLY  = 4;
    localparam int CMD_SHY  = 3;
    localparam int CMD_ACC  = 2;
    localparam int CMD_INC  = 1;
    localparam int CMD_SEL  = 0;

    localparam int STS_X0   = 3;
    localparam int STS_Y0   = 2;
    localparam int STS_XLSB = 1;
    localparam int STS_YLSB = 0;

endpackage

// File: rtl/axby_iter_cnt.sv
// axby_iter_cnt: iteration counter with clear priority over enable and a terminal flag at WIDTH-1.
module axby_iter_cnt #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    output logic [$clog2(WIDTH)-1:0] o_cnt,
    output logic                     o_term
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt  = r_cnt;
    assign o_term = r_cnt == LAST;

endmodule

// File: rtl/axby_seq.sv
// axby_seq: START/BUSY/SETRDYP sequencer driving the shift-and-add R = A*X + B*Y datapath.
// Define AXBY_SEQ_EARLY_EXIT_EN to leave a multiply loop as soon as its operand register reads zero.
module axby_seq
    import axby_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic [3:0]               STATUS,
    output logic [7:0]               CMD,
    output logic                     SETRDYP,
    output logic                     BUSY,
    output logic [$clog2(WIDTH)-1:0] CNT
);
    state_t r_state;
    state_t w_next;
    logic   w_term;
    logic   w_x_exit;
    logic   w_y_exit;
    logic   w_run;
    logic   w_clr;

`ifdef AXBY_SEQ_EARLY_EXIT_EN
    assign w_x_exit = STATUS[STS_X0];
    assign w_y_exit = STATUS[STS_Y0];
`else
    logic w_unused;
    assign w_unused = ^STATUS[STS_X0:STS_Y0];
    assign w_x_exit = 1'b0;
    assign w_y_exit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        r_state <= !RST_N ? ST_IDLE : w_next;
    end

    // early exit is tested ahead of the terminal count so a zero operand wins
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next = START ? ST_INIT : ST_IDLE;
            ST_INIT: w_next = ST_MX;
            ST_MX:   w_next = (w_x_exit || w_term) ? ST_MY : ST_MX;
            ST_MY:   w_next = (w_y_exit || w_term) ? ST_DONE : ST_MY;
            ST_DONE: w_next = ST_HOLD;
            ST_HOLD: w_next = START ? ST_HOLD : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // the counter only runs inside a loop and restarts at 0 on every state change
    assign w_run = (r_state == ST_MX) || (r_state == ST_MY);
    assign w_clr = !w_run || (w_next != r_state);

    axby_iter_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk    (clk),
        .i_rst_n(RST_N),
        .i_clr  (w_clr),
        .i_en   (w_run),
        .o_cnt  (CNT),
        .o_term (w_term)
    );

    always_comb begin
        CMD = '0;
        case (r_state)
            ST_INIT: begin
                CMD[CMD_RESI] = 1'b1;
                CMD[CMD_PLX]  = 1'b1;
                CMD[CMD_PLY]  = 1'b1;
            end
            ST_MX: begin
                CMD[CMD_SHX] = !w_x_exit;
                CMD[CMD_INC] = !w_x_exit;
                CMD[CMD_ACC] = !w_x_exit && STATUS[STS_XLSB];
            end
            ST_MY: begin
                CMD[CMD_SHY] = !w_y_exit;
                CMD[CMD_INC] = !w_y_exit;
                CMD[CMD_SEL] = !w_y_exit;
                CMD[CMD_ACC] = !w_y_exit && STATUS[STS_YLSB];
            end
            default: CMD = '0;
        endcase
    end

    assign SETRDYP = r_state == ST_DONE;
    assign BUSY    = r_state inside {ST_INIT, ST_MX, ST_MY, ST_DONE};

endmodule
